tage_update: RTL
================

TAGE_UPDATE -- requirements
Module: tage_update

Parameters
REQ-001 The block SHALL have parameter CL, default 3, giving the saturating prediction-counter width.
REQ-002 The block SHALL have parameter TW, default 8, giving the partial-tag width.

Interface
REQ-003 CLK  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 upd_valid  input  1  a resolved branch update is offered.
REQ-006 upd_ready  output  1  block can accept an update.
REQ-007 upd_taken  input  1  actual branch outcome, 1 = taken.
REQ-008 upd_pred  input  1  prediction that was issued for this branch.
REQ-009 upd_tag  input  TW  partial tag of the branch, written on allocation.
REQ-010 tag_eq  input  4  tag-hit flags; bit k-1 = bank k.
REQ-011 u_bit  input  4  useful bits of the indexed entries; bit k-1 = bank k.
REQ-012 Bimodal_C_bit, C_bit_Bank1..C_bit_Bank4  input  CL each  current counters of the indexed entries.
REQ-013 prov_we  output  5  one-hot provider counter write; bit0 = bimodal, bit k = bank k.
REQ-014 prov_ctr  output  CL  new provider counter value.
REQ-015 prov_u_we  output  1  write prov_u into the provider bank's useful bit.
REQ-016 prov_u  output  1  new provider useful bit.
REQ-017 alloc_we  output  4  one-hot allocation write; bit k-1 = bank k; writes tag, counter and u=0.
REQ-018 alloc_ctr  output  CL  initial counter for the allocated entry.
REQ-019 alloc_tag  output  TW  tag for the allocated entry.
REQ-020 age_we  output  4  clear the useful bit in the flagged banks.
REQ-021 mispredict_cnt  output  16  count of mispredicted updates.

Function
REQ-022 FSM states SHALL be IDLE, CALC and WRITE; upd_ready SHALL be 1 only in IDLE.
REQ-023 An update SHALL be accepted when upd_valid=1 and upd_ready=1 in cycle T, and all inputs SHALL be registered at that edge.
- State sequence: CALC in T+1, WRITE in T+2, IDLE in T+3.
REQ-024 upd_valid while upd_ready=0 SHALL be ignored, with no effect on state.
REQ-025 Provider SHALL be the highest-numbered bank with tag_eq set, or bimodal if there is no hit.
REQ-026 Alternate prediction SHALL be the MSB of the next-lower hitting bank's counter, or Bimodal_C_bit[CL-1] if there is none.
REQ-027 Provider counter update SHALL saturate:
- increment when upd_taken=1, with a maximum of 2^CL-1;
- decrement when upd_taken=0, with a minimum of 0.
REQ-028 prov_u_we SHALL be 1 only when the provider is a tagged bank and the provider MSB differs from the alternate prediction.
- prov_u = (provider MSB == upd_taken).
REQ-029 Misprediction SHALL mean upd_pred != upd_taken.
REQ-030 On misprediction with provider < bank4, allocation SHALL target the lowest bank above the provider with u_bit=0.
- alloc_ctr = 2^(CL-1) if taken, else 2^(CL-1)-1.
- alloc_tag = upd_tag.
REQ-031 If no bank above the provider has u_bit=0, alloc_we SHALL be 0 and age_we SHALL flag every bank above the provider.
REQ-032 Provider = bank4 or a correct prediction SHALL produce no allocation and no aging.
REQ-033 All write strobes SHALL be high only during the WRITE cycle, for exactly one cycle, and 0 otherwise.
- Data outputs hold their last value.
REQ-034 mispredict_cnt SHALL increment in the WRITE cycle of a mispredicted update and saturate at 16'hFFFF.

Reset
REQ-035 reset=0 at a clock edge SHALL force IDLE, including mid-operation, and the aborted update SHALL produce no strobes.
REQ-036 reset=0 at a clock edge SHALL zero all outputs, prov_ctr, alloc_ctr, alloc_tag and mispredict_cnt.
- upd_ready = 1 in the cycle after reset is released.

Verification
REQ-037 No hit, Bimodal_C_bit=3'b011, taken, pred=0 -> T+2: prov_we=00001, prov_ctr=100, alloc_we=0001, alloc_ctr=100, mispredict_cnt=1.
REQ-038 tag_eq=0101, C_bit_Bank3=111, Bank1=000, taken, pred=1 -> prov_we=01000, prov_ctr=111, prov_u_we=1, prov_u=1, no alloc.
REQ-039 Provider bank1, pred wrong, u_bit=1110 -> age_we=1110, alloc_we=0000; with u_bit=1010 -> alloc_we=0100.
REQ-040 Provider bank4, C_bit_Bank4=000, not taken, pred=1 -> prov_ctr=000, alloc_we=0, age_we=0.
REQ-041 Second upd_valid at T+1, then reset=0 at T+1 -> no strobes at T+2, upd_ready=1 after reset is released, mispredict_cnt=0.
REQ-042 65537 consecutive mispredicts -> mispredict_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/tage_update_if.sv
// Update-side bundle of the TAGE predictor: the resolved-branch request, the indexed
// table state, and the write strobes and data returned to the tables.
interface tage_update_if #(
   parameter int CL = 3,
   parameter int TW = 8
);
   logic          upd_valid;
   logic          upd_ready;
   logic          upd_taken;
   logic          upd_pred;
   logic [TW-1:0] upd_tag;
   logic [3:0]    tag_eq;
   logic [3:0]    u_bit;
   logic [CL-1:0] Bimodal_C_bit;
   logic [CL-1:0] C_bit_Bank1;
   logic [CL-1:0] C_bit_Bank2;
   logic [CL-1:0] C_bit_Bank3;
   logic [CL-1:0] C_bit_Bank4;
   logic [4:0]    prov_we;
   logic [CL-1:0] prov_ctr;
   logic          prov_u_we;
   logic          prov_u;
   logic [3:0]    alloc_we;
   logic [CL-1:0] alloc_ctr;
   logic [TW-1:0] alloc_tag;
   logic [3:0]    age_we;
   logic [15:0]   mispredict_cnt;

   modport master (
      output upd_valid, upd_taken, upd_pred, upd_tag, tag_eq, u_bit,
             Bimodal_C_bit, C_bit_Bank1, C_bit_Bank2, C_bit_Bank3, C_bit_Bank4,
      input  upd_ready, prov_we, prov_ctr, prov_u_we, prov_u, alloc_we,
             alloc_ctr, alloc_tag, age_we, mispredict_cnt
   );

   modport slave (
      input  upd_valid, upd_taken, upd_pred, upd_tag, tag_eq, u_bit,
             Bimodal_C_bit, C_bit_Bank1, C_bit_Bank2, C_bit_Bank3, C_bit_Bank4,
      output upd_ready, prov_we, prov_ctr, prov_u_we, prov_u, alloc_we,
             alloc_ctr, alloc_tag, age_we, mispredict_cnt
   );
endinterface

// File: rtl/tage_update.sv
// TAGE update engine: captures one resolved branch, picks provider/alternate, and
// emits a single WRITE cycle of counter, useful-bit, allocation and aging strobes.
module tage_update #(
   parameter int CL = 3,
   parameter int TW = 8
) (
   input  logic         CLK,
   input  logic         reset,
   tage_update_if.slave u
);

   typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

   localparam logic [CL-1:0] CTR_MAX   = {CL{1'b1}};
   localparam logic [CL-1:0] ALLOC_TKN = CL'(1) << (CL-1);
   localparam logic [CL-1:0] ALLOC_NTK = ALLOC_TKN - CL'(1);

   function automatic logic [CL-1:0] sat_update(input logic [CL-1:0] c, input logic up);
      if (up) return (c == CTR_MAX) ? c : c + CL'(1);
      else    return (c == '0)      ? c : c - CL'(1);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   function automatic logic [3:0] lowest_set(input logic [3:0] v);
      return v & (~v + 4'd1);
   endfunction

   state_t state, state_nxt;

   // Stage 0: inputs captured at the accepting edge
   logic          taken_p0, pred_p0;
   logic [TW-1:0] tag_p0;
   logic [3:0]    tag_eq_p0, u_bit_p0;
   logic [CL-1:0] ctr_p0 [5];

   always_ff @(posedge CLK) begin
      if (state == IDLE && u.upd_valid) begin
         taken_p0  <= u.upd_taken;
         pred_p0   <= u.upd_pred;
         tag_p0    <= u.upd_tag;
         tag_eq_p0 <= u.tag_eq;
         u_bit_p0  <= u.u_bit;
         ctr_p0[0] <= u.Bimodal_C_bit;
         ctr_p0[1] <= u.C_bit_Bank1;
         ctr_p0[2] <= u.C_bit_Bank2;
         ctr_p0[3] <= u.C_bit_Bank3;
         ctr_p0[4] <= u.C_bit_Bank4;
      end
   end

   // Stage 1: provider / alternate selection and allocation decision (CALC)
   logic [2:0]    prov_idx;
   logic [CL-1:0] prov_c;
   logic          alt_pred, prov_msb, mispred;
   logic [3:0]    above, free, alloc_oh, age_mask;

   always_comb begin
      prov_idx = '0;
      for (int k = 1; k <= 4; k++)
         if (tag_eq_p0[k-1]) prov_idx = 3'(k);
      alt_pred = ctr_p0[0][CL-1];
      for (int k = 1; k < 4; k++)
         if (tag_eq_p0[k-1] && (3'(k) < prov_idx)) alt_pred = ctr_p0[k][CL-1];
      case (prov_idx)
         3'd1:    prov_c = ctr_p0[1];
         3'd2:    prov_c = ctr_p0[2];
         3'd3:    prov_c = ctr_p0[3];
         3'd4:    prov_c = ctr_p0[4];
         default: prov_c = ctr_p0[0];
      endcase
      prov_msb = prov_c[CL-1];
      mispred  = (pred_p0 != taken_p0);
      above    = '0;
      for (int k = 1; k <= 4; k++)
         above[k-1] = (3'(k) > prov_idx);
      free     = above & ~u_bit_p0;
      alloc_oh = mispred ? lowest_set(free) : 4'b0000;
      // Nothing free above the provider: age those banks instead of allocating
      age_mask = (mispred && free == 4'b0000) ? above : 4'b0000;
   end

   logic [4:0]    prov_we_p1;
   logic          prov_u_we_p1, prov_u_p1;
   logic [3:0]    alloc_we_p1, age_we_p1;
   logic [CL-1:0] prov_ctr_p1, alloc_ctr_p1;
   logic [TW-1:0] alloc_tag_p1;
   logic [15:0]   mispredict_cnt_r;

   always_ff @(posedge CLK) begin
      if (!reset) begin
         prov_we_p1       <= '0;
         prov_u_we_p1     <= 1'b0;
         prov_u_p1        <= 1'b0;
         alloc_we_p1      <= '0;
         age_we_p1        <= '0;
         prov_ctr_p1      <= '0;
         alloc_ctr_p1     <= '0;
         alloc_tag_p1     <= '0;
         mispredict_cnt_r <= '0;
      end else if (state == CALC) begin
         prov_we_p1   <= 5'b00001 << prov_idx;
         prov_u_we_p1 <= (prov_idx != 3'd0) && (prov_msb != alt_pred);
         prov_u_p1    <= (prov_msb == taken_p0);
         prov_ctr_p1  <= sat_update(prov_c, taken_p0);
         alloc_we_p1  <= alloc_oh;
         age_we_p1    <= age_mask;
         if (alloc_oh != 4'b0000) begin
            alloc_ctr_p1 <= taken_p0 ? ALLOC_TKN : ALLOC_NTK;
            alloc_tag_p1 <= tag_p0;
         end
         if (mispred) mispredict_cnt_r <= sat_inc16(mispredict_cnt_r);
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Stage 2: strobes exposed only while in WRITE
   always_comb begin
      state_nxt   = state;
      u.upd_ready = 1'b0;
      u.prov_we   = '0;
      u.prov_u_we = 1'b0;
      u.alloc_we  = '0;
      u.age_we    = '0;
      case (state)
         IDLE: begin
            u.upd_ready = 1'b1;
            if (u.upd_valid) state_nxt = CALC;
         end
         CALC: state_nxt = WRITE;
         WRITE: begin
            u.prov_we   = prov_we_p1;
            u.prov_u_we = prov_u_we_p1;
            u.alloc_we  = alloc_we_p1;
            u.age_we    = age_we_p1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign u.prov_ctr       = prov_ctr_p1;
   assign u.prov_u         = prov_u_p1;
   assign u.alloc_ctr      = alloc_ctr_p1;
   assign u.alloc_tag      = alloc_tag_p1;
   assign u.mispredict_cnt = mispredict_cnt_r;

endmodule
